// File: rtl/proc_io_responder.sv
// Device-side peripheral responder: routes core command strobes to TX FIFO, PPU and
// accelerator, and paces key / Ethernet-RX events back to the core as interrupt pulses.
module proc_io_responder #(
  parameter int TX_DEPTH = 4,
  parameter int RX_DEPTH = 4,
  parameter int IRQ_GAP  = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        snd,
  input  logic        ppu_send,
  input  logic        uad,
  input  logic        sac,
  input  logic [31:0] interface_data,
  output logic        interrupt_key,
  output logic        interrupt_eth,
  output logic [31:0] interrupt_source_data,
  output logic        accelerator_data,
  input  logic        key_valid,
  input  logic [7:0]  key_code,
  input  logic        eth_rx_valid,
  input  logic [31:0] eth_rx_data,
  output logic        eth_tx_valid,
  output logic [31:0] eth_tx_data,
  input  logic        eth_tx_ready,
  output logic        ppu_valid,
  output logic [31:0] ppu_data,
  input  logic        ppu_ready,
  output logic        accel_start,
  output logic [31:0] accel_operand,
  input  logic        accel_done,
  input  logic        accel_result,
  output logic [3:0]  err_sticky
);

  localparam int TPW = $clog2(TX_DEPTH);
  localparam int TCW = $clog2(TX_DEPTH + 1);
  localparam int RPW = $clog2(RX_DEPTH);
  localparam int RCW = $clog2(RX_DEPTH + 1);
  localparam int GW  = $clog2(IRQ_GAP + 1);
  localparam logic [TCW-1:0] TX_FULL  = TCW'(TX_DEPTH);
  localparam logic [RCW-1:0] RX_FULL  = RCW'(RX_DEPTH);
  localparam logic [GW-1:0]  GAP_INIT = GW'(IRQ_GAP - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FIRE = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  // TX FIFO
  logic [31:0]    tx_mem_q [TX_DEPTH];
  logic [TPW-1:0] tx_wr_q, tx_rd_q;
  logic [TCW-1:0] tx_cnt_q, tx_cnt_d;
  logic           tx_full, tx_pop, tx_push;

  assign tx_full      = (tx_cnt_q == TX_FULL);
  assign eth_tx_valid = (tx_cnt_q != '0);
  assign eth_tx_data  = tx_mem_q[tx_rd_q];
  assign tx_pop       = eth_tx_valid && eth_tx_ready;
  assign tx_push      = snd && (!tx_full || tx_pop);

  always_comb begin
    tx_cnt_d = tx_cnt_q;
    if (tx_push && !tx_pop)      tx_cnt_d = tx_cnt_q + 1'b1;
    else if (!tx_push && tx_pop) tx_cnt_d = tx_cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TX_DEPTH; i++) tx_mem_q[i] <= '0;
      tx_wr_q  <= '0;
      tx_rd_q  <= '0;
      tx_cnt_q <= '0;
    end else begin
      if (tx_push) begin
        tx_mem_q[tx_wr_q] <= interface_data;
        tx_wr_q           <= tx_wr_q + 1'b1;
      end
      if (tx_pop) tx_rd_q <= tx_rd_q + 1'b1;
      tx_cnt_q <= tx_cnt_d;
    end
  end

  // PPU mailbox: a send in the accept cycle reloads without a bubble
  logic        ppu_valid_q;
  logic [31:0] ppu_data_q;
  logic        ppu_accept, ppu_load;

  assign ppu_accept = ppu_valid_q && ppu_ready;
  assign ppu_load   = ppu_send && (!ppu_valid_q || ppu_accept);
  assign ppu_valid  = ppu_valid_q;
  assign ppu_data   = ppu_data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ppu_valid_q <= 1'b0;
      ppu_data_q  <= '0;
    end else if (ppu_load) begin
      ppu_valid_q <= 1'b1;
      ppu_data_q  <= interface_data;
    end else if (ppu_accept) begin
      ppu_valid_q <= 1'b0;
    end
  end

  // Start is registered so a same-cycle uad/sac pair starts on the freshly loaded operand
  logic        accel_start_q;
  logic [31:0] accel_operand_q;
  logic        accel_data_q;

  assign accel_start      = accel_start_q;
  assign accel_operand    = accel_operand_q;
  assign accelerator_data = accel_data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      accel_start_q   <= 1'b0;
      accel_operand_q <= '0;
      accel_data_q    <= 1'b0;
    end else begin
      accel_start_q <= sac;
      if (uad)        accel_operand_q <= interface_data;
      if (accel_done) accel_data_q    <= accel_result;
    end
  end

  // Event capture and IRQ pacing
  logic           key_full_q;
  logic [7:0]     key_code_q;
  logic [31:0]    rx_mem_q [RX_DEPTH];
  logic [RPW-1:0] rx_wr_q, rx_rd_q;
  logic [RCW-1:0] rx_cnt_q, rx_cnt_d;
  logic           rx_full, rx_pop, rx_push;
  logic [1:0]     state_q, state_d;
  logic [GW-1:0]  gap_cnt_q, gap_cnt_d;
  logic           pending, gap_last, consume, key_free;
  logic           irq_key_q, irq_eth_q;
  logic [31:0]    src_q;

  assign pending  = key_full_q || (rx_cnt_q != '0);
  assign gap_last = (state_q == S_GAP) && (gap_cnt_q == '0);
  assign consume  = pending && ((state_q == S_IDLE) || gap_last);
  assign key_free = consume && key_full_q;
  assign rx_pop   = consume && !key_full_q;
  assign rx_full  = (rx_cnt_q == RX_FULL);
  assign rx_push  = eth_rx_valid && (!rx_full || rx_pop);

  assign interrupt_key         = irq_key_q;
  assign interrupt_eth         = irq_eth_q;
  assign interrupt_source_data = src_q;

  always_comb begin
    rx_cnt_d = rx_cnt_q;
    if (rx_push && !rx_pop)      rx_cnt_d = rx_cnt_q + 1'b1;
    else if (!rx_push && rx_pop) rx_cnt_d = rx_cnt_q - 1'b1;
  end

  // The last GAP cycle may launch the next event directly, giving IRQ_GAP+1 pulse spacing
  always_comb begin
    state_d   = state_q;
    gap_cnt_d = gap_cnt_q;
    case (state_q)
      S_IDLE: if (consume) state_d = S_FIRE;
      S_FIRE: begin
        state_d   = S_GAP;
        gap_cnt_d = GAP_INIT;
      end
      S_GAP: begin
        if (gap_cnt_q == '0) state_d = consume ? S_FIRE : S_IDLE;
        else                 gap_cnt_d = gap_cnt_q - 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_full_q <= 1'b0;
      key_code_q <= '0;
      for (int i = 0; i < RX_DEPTH; i++) rx_mem_q[i] <= '0;
      rx_wr_q    <= '0;
      rx_rd_q    <= '0;
      rx_cnt_q   <= '0;
      state_q    <= S_IDLE;
      gap_cnt_q  <= '0;
      irq_key_q  <= 1'b0;
      irq_eth_q  <= 1'b0;
      src_q      <= '0;
    end else begin
      if (key_valid) begin
        key_full_q <= 1'b1;
        key_code_q <= key_code;
      end else if (key_free) begin
        key_full_q <= 1'b0;
      end
      if (rx_push) begin
        rx_mem_q[rx_wr_q] <= eth_rx_data;
        rx_wr_q           <= rx_wr_q + 1'b1;
      end
      if (rx_pop) rx_rd_q <= rx_rd_q + 1'b1;
      rx_cnt_q  <= rx_cnt_d;
      state_q   <= state_d;
      gap_cnt_q <= gap_cnt_d;
      irq_key_q <= key_free;
      irq_eth_q <= rx_pop;
      if (consume) src_q <= key_full_q ? {24'h0, key_code_q} : rx_mem_q[rx_rd_q];
    end
  end

  logic [3:0] err_q;
  assign err_sticky = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= '0;
    end else begin
      if (snd && tx_full && !tx_pop)             err_q[0] <= 1'b1;
      if (ppu_send && ppu_valid_q && !ppu_ready) err_q[1] <= 1'b1;
      if (eth_rx_valid && rx_full && !rx_pop)    err_q[2] <= 1'b1;
      if (key_valid && key_full_q && !key_free)  err_q[3] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_proc_io_responder.sv
// Bench for proc_io_responder: directed vector table, multi-cycle scenarios and a
// randomized run against a queue-based reference model.
module tb_proc_io_responder;
  localparam int TX_DEPTH = 4;
  localparam int RX_DEPTH = 4;
  localparam int IRQ_GAP  = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        snd, ppu_send, uad, sac;
  logic [31:0] interface_data;
  logic        interrupt_key, interrupt_eth;
  logic [31:0] interrupt_source_data;
  logic        accelerator_data;
  logic        key_valid;
  logic [7:0]  key_code;
  logic        eth_rx_valid;
  logic [31:0] eth_rx_data;
  logic        eth_tx_valid;
  logic [31:0] eth_tx_data;
  logic        eth_tx_ready;
  logic        ppu_valid;
  logic [31:0] ppu_data;
  logic        ppu_ready;
  logic        accel_start;
  logic [31:0] accel_operand;
  logic        accel_done, accel_result;
  logic [3:0]  err_sticky;

  always #5 clk = ~clk;

  proc_io_responder #(.TX_DEPTH(TX_DEPTH), .RX_DEPTH(RX_DEPTH), .IRQ_GAP(IRQ_GAP)) dut (
    .clk(clk), .rst_n(rst_n), .snd(snd), .ppu_send(ppu_send), .uad(uad), .sac(sac),
    .interface_data(interface_data), .interrupt_key(interrupt_key), .interrupt_eth(interrupt_eth),
    .interrupt_source_data(interrupt_source_data), .accelerator_data(accelerator_data),
    .key_valid(key_valid), .key_code(key_code), .eth_rx_valid(eth_rx_valid), .eth_rx_data(eth_rx_data),
    .eth_tx_valid(eth_tx_valid), .eth_tx_data(eth_tx_data), .eth_tx_ready(eth_tx_ready),
    .ppu_valid(ppu_valid), .ppu_data(ppu_data), .ppu_ready(ppu_ready), .accel_start(accel_start),
    .accel_operand(accel_operand), .accel_done(accel_done), .accel_result(accel_result),
    .err_sticky(err_sticky)
  );

  int checks = 0;
  int failures = 0;
  int stepn = 0;
  bit use_model = 0;
  int p_step[$];
  bit p_key[$];
  logic [31:0] p_src[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: queues for FIFOs, earliest-launch cycle for IRQ pacing
  logic [31:0] m_txq[$];
  logic [31:0] m_rxq[$];
  bit          m_ppu_v, m_start, m_accd, m_key_occ, m_irq_k, m_irq_e;
  logic [31:0] m_ppu_d, m_op, m_src;
  logic [7:0]  m_key_code;
  logic [3:0]  m_err;
  int          m_cyc, m_next_ok;

  task automatic model_reset();
    m_txq.delete(); m_rxq.delete();
    m_ppu_v = 0; m_start = 0; m_accd = 0; m_key_occ = 0; m_irq_k = 0; m_irq_e = 0;
    m_ppu_d = '0; m_op = '0; m_src = '0; m_key_code = '0; m_err = '0;
    m_cyc = 0; m_next_ok = 0;
  endtask

  task automatic model_step();
    bit consume;
    if (m_txq.size() > 0 && eth_tx_ready) void'(m_txq.pop_front());
    if (snd) begin
      if (m_txq.size() < TX_DEPTH) m_txq.push_back(interface_data);
      else m_err[0] = 1'b1;
    end
    if (m_ppu_v && ppu_ready) m_ppu_v = 0;
    if (ppu_send) begin
      if (!m_ppu_v) begin m_ppu_v = 1; m_ppu_d = interface_data; end
      else m_err[1] = 1'b1;
    end
    m_start = sac;
    if (uad) m_op = interface_data;
    if (accel_done) m_accd = accel_result;
    consume = (m_key_occ || m_rxq.size() > 0) && (m_cyc >= m_next_ok);
    m_irq_k = 0;
    m_irq_e = 0;
    if (consume) begin
      m_next_ok = m_cyc + IRQ_GAP + 1;
      if (m_key_occ) begin
        m_irq_k = 1; m_src = {24'h0, m_key_code}; m_key_occ = 0;
      end else begin
        m_irq_e = 1; m_src = m_rxq.pop_front();
      end
    end
    if (key_valid) begin
      if (m_key_occ) m_err[3] = 1'b1;
      m_key_occ = 1; m_key_code = key_code;
    end
    if (eth_rx_valid) begin
      if (m_rxq.size() < RX_DEPTH) m_rxq.push_back(eth_rx_data);
      else m_err[2] = 1'b1;
    end
    m_cyc++;
  endtask

  task automatic compare_model();
    chk("rnd_irq_key", interrupt_key, m_irq_k);
    chk("rnd_irq_eth", interrupt_eth, m_irq_e);
    chk("rnd_src", interrupt_source_data, m_src);
    chk("rnd_tx_valid", eth_tx_valid, m_txq.size() > 0);
    if (m_txq.size() > 0) chk("rnd_tx_data", eth_tx_data, m_txq[0]);
    chk("rnd_ppu_valid", ppu_valid, m_ppu_v);
    chk("rnd_ppu_data", ppu_data, m_ppu_d);
    chk("rnd_start", accel_start, m_start);
    chk("rnd_operand", accel_operand, m_op);
    chk("rnd_accd", accelerator_data, m_accd);
    chk("rnd_err", err_sticky, m_err);
  endtask

  task automatic clear_inputs();
    snd = 0; ppu_send = 0; uad = 0; sac = 0; interface_data = '0;
    key_valid = 0; key_code = '0; eth_rx_valid = 0; eth_rx_data = '0;
    eth_tx_ready = 0; ppu_ready = 0; accel_done = 0; accel_result = 0;
  endtask

  task automatic step();
    @(posedge clk);
    if (use_model) model_step();
    #1;
    stepn++;
    if (interrupt_key || interrupt_eth) begin
      p_step.push_back(stepn - 1);
      p_key.push_back(interrupt_key);
      p_src.push_back(interrupt_source_data);
    end
    if (use_model) compare_model();
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    stepn = 0;
    p_step.delete(); p_key.delete(); p_src.delete();
    model_reset();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_irq_key"}, interrupt_key, 0);
    chk({tag, "_irq_eth"}, interrupt_eth, 0);
    chk({tag, "_src"}, interrupt_source_data, 0);
    chk({tag, "_accd"}, accelerator_data, 0);
    chk({tag, "_tx_valid"}, eth_tx_valid, 0);
    chk({tag, "_tx_data"}, eth_tx_data, 0);
    chk({tag, "_ppu_valid"}, ppu_valid, 0);
    chk({tag, "_ppu_data"}, ppu_data, 0);
    chk({tag, "_start"}, accel_start, 0);
    chk({tag, "_operand"}, accel_operand, 0);
    chk({tag, "_err"}, err_sticky, 0);
  endtask

  typedef struct {
    logic        snd, ppu_send, uad, sac;
    logic [31:0] data;
    logic        ppu_ready, done, result;
    logic        e_txv;
    logic [31:0] e_txd;
    logic        e_ppuv;
    logic [31:0] e_ppud;
    logic        e_start;
    logic [31:0] e_op;
    logic        e_accd;
    logic [3:0]  e_err;
  } vec_t;

  function automatic vec_t mk(input logic s, pp, u, sc, input logic [31:0] d, input logic pr, dn, rs,
                              input logic txv, input logic [31:0] txd, input logic pv,
                              input logic [31:0] pd, input logic st, input logic [31:0] op,
                              input logic ad, input logic [3:0] er);
    vec_t v;
    v.snd = s; v.ppu_send = pp; v.uad = u; v.sac = sc; v.data = d;
    v.ppu_ready = pr; v.done = dn; v.result = rs;
    v.e_txv = txv; v.e_txd = txd; v.e_ppuv = pv; v.e_ppud = pd;
    v.e_start = st; v.e_op = op; v.e_accd = ad; v.e_err = er;
    return v;
  endfunction

  vec_t vt[14];

  initial begin
    logic [31:0] got[$];
    logic [31:0] exp_tx[4];
    //            snd pp uad sac data        prdy dn rs | txv txd  pv pd         st op      ad err
    vt[0]  = mk(0, 0, 1, 1, 32'h0000000A, 0, 0, 0,  0, 32'h0,  0, 32'h0,      1, 32'h0A, 0, 4'h0);
    vt[1]  = mk(0, 0, 0, 0, 32'h0,        0, 0, 0,  0, 32'h0,  0, 32'h0,      0, 32'h0A, 0, 4'h0);
    vt[2]  = mk(0, 0, 0, 0, 32'h0,        0, 1, 1,  0, 32'h0,  0, 32'h0,      0, 32'h0A, 1, 4'h0);
    vt[3]  = mk(0, 0, 0, 0, 32'h0,        0, 0, 0,  0, 32'h0,  0, 32'h0,      0, 32'h0A, 1, 4'h0);
    vt[4]  = mk(0, 0, 0, 0, 32'h0,        0, 1, 0,  0, 32'h0,  0, 32'h0,      0, 32'h0A, 0, 4'h0);
    vt[5]  = mk(0, 1, 0, 0, 32'h0000CAFE, 0, 0, 0,  0, 32'h0,  1, 32'hCAFE,   0, 32'h0A, 0, 4'h0);
    vt[6]  = mk(0, 1, 0, 0, 32'h0000BEEF, 0, 0, 0,  0, 32'h0,  1, 32'hCAFE,   0, 32'h0A, 0, 4'h2);
    vt[7]  = mk(0, 0, 0, 0, 32'h0,        1, 0, 0,  0, 32'h0,  0, 32'hCAFE,   0, 32'h0A, 0, 4'h2);
    vt[8]  = mk(0, 1, 0, 0, 32'h00001234, 0, 0, 0,  0, 32'h0,  1, 32'h1234,   0, 32'h0A, 0, 4'h2);
    vt[9]  = mk(0, 1, 0, 0, 32'h00005678, 1, 0, 0,  0, 32'h0,  1, 32'h5678,   0, 32'h0A, 0, 4'h2);
    vt[10] = mk(0, 0, 0, 0, 32'h0,        1, 0, 0,  0, 32'h0,  0, 32'h5678,   0, 32'h0A, 0, 4'h2);
    vt[11] = mk(1, 0, 0, 0, 32'h00000011, 0, 0, 0,  1, 32'h11, 0, 32'h5678,   0, 32'h0A, 0, 4'h2);
    vt[12] = mk(0, 0, 0, 1, 32'h0,        0, 0, 0,  1, 32'h11, 0, 32'h5678,   1, 32'h0A, 0, 4'h2);
    vt[13] = mk(0, 0, 1, 0, 32'h00000077, 0, 0, 0,  1, 32'h11, 0, 32'h5678,   0, 32'h77, 0, 4'h2);

    // Reset state
    clear_inputs();
    rst_n = 0;
    @(posedge clk);
    #1;
    check_all_zero("reset");

    // Directed vector table
    do_reset();
    for (int i = 0; i < 14; i++) begin
      snd = vt[i].snd; ppu_send = vt[i].ppu_send; uad = vt[i].uad; sac = vt[i].sac;
      interface_data = vt[i].data; ppu_ready = vt[i].ppu_ready;
      accel_done = vt[i].done; accel_result = vt[i].result;
      step();
      chk($sformatf("vec%0d_tx_valid", i), eth_tx_valid, vt[i].e_txv);
      if (vt[i].e_txv) chk($sformatf("vec%0d_tx_data", i), eth_tx_data, vt[i].e_txd);
      chk($sformatf("vec%0d_ppu_valid", i), ppu_valid, vt[i].e_ppuv);
      chk($sformatf("vec%0d_ppu_data", i), ppu_data, vt[i].e_ppud);
      chk($sformatf("vec%0d_start", i), accel_start, vt[i].e_start);
      chk($sformatf("vec%0d_operand", i), accel_operand, vt[i].e_op);
      chk($sformatf("vec%0d_accd", i), accelerator_data, vt[i].e_accd);
      chk($sformatf("vec%0d_err", i), err_sticky, vt[i].e_err);
      $display("vec %0d applied", i);
    end

    // TX overflow then drain
    do_reset();
    exp_tx[0] = 32'h11; exp_tx[1] = 32'h22; exp_tx[2] = 32'h33; exp_tx[3] = 32'h44;
    for (int i = 1; i <= 5; i++) begin
      snd = 1; interface_data = 32'(i * 'h11);
      step();
    end
    snd = 0;
    step();
    chk("tx_full_valid", eth_tx_valid, 1);
    chk("tx_full_head", eth_tx_data, 32'h11);
    chk("tx_drop_err", err_sticky[0], 1);
    eth_tx_ready = 1;
    for (int i = 0; i < 8; i++) begin
      if (eth_tx_valid) got.push_back(eth_tx_data);
      step();
    end
    chk("tx_drain_count", got.size(), 4);
    for (int i = 0; i < 4; i++) if (i < got.size()) chk($sformatf("tx_drain%0d", i), got[i], exp_tx[i]);
    chk("tx_empty", eth_tx_valid, 0);
    $display("seq tx_overflow drained %0d words", got.size());

    // Simultaneous key + RX event
    do_reset();
    key_valid = 1; key_code = 8'h5A; eth_rx_valid = 1; eth_rx_data = 32'hDEADBEEF;
    step();
    clear_inputs();
    repeat (19) step();
    chk("kr_pulses", p_step.size(), 2);
    if (p_step.size() == 2) begin
      chk("kr_key_at", p_step[0], 1);
      chk("kr_key_kind", p_key[0], 1);
      chk("kr_key_src", p_src[0], 32'h0000005A);
      chk("kr_eth_at", p_step[1], 1 + IRQ_GAP + 1);
      chk("kr_eth_kind", p_key[1], 0);
      chk("kr_eth_src", p_src[1], 32'hDEADBEEF);
    end
    chk("kr_src_hold", interrupt_source_data, 32'hDEADBEEF);
    $display("seq key_rx pulses=%0d", p_step.size());

    // RX burst during GAP overflows the RX FIFO
    do_reset();
    key_valid = 1; key_code = 8'h33;
    step();
    clear_inputs();
    repeat (2) step();
    for (int i = 1; i <= 5; i++) begin
      eth_rx_valid = 1; eth_rx_data = 32'hA0000000 + 32'(i);
      step();
    end
    clear_inputs();
    repeat (35) step();
    chk("rxb_pulses", p_step.size(), 5);
    if (p_step.size() == 5) begin
      chk("rxb_key_at", p_step[0], 1);
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("rxb_eth%0d_at", i), p_step[i+1], 10 + i * (IRQ_GAP + 1));
        chk($sformatf("rxb_eth%0d_kind", i), p_key[i+1], 0);
        chk($sformatf("rxb_eth%0d_src", i), p_src[i+1], 32'hA0000000 + 32'(i + 1));
      end
    end
    chk("rxb_err", err_sticky, 4'b0100);
    $display("seq rx_burst pulses=%0d", p_step.size());

    // Reset in the middle of GAP with RX words queued
    do_reset();
    key_valid = 1; key_code = 8'h33;
    step();
    clear_inputs();
    repeat (2) step();
    eth_rx_valid = 1; eth_rx_data = 32'h0BAD0001;
    step();
    eth_rx_data = 32'h0BAD0002;
    step();
    clear_inputs();
    repeat (2) step();
    rst_n = 0;
    #1;
    check_all_zero("midrst");
    @(posedge clk);
    #1;
    rst_n = 1;
    p_step.delete(); p_key.delete(); p_src.delete();
    repeat (30) step();
    chk("midrst_no_pulse", p_step.size(), 0);
    chk("midrst_src", interrupt_source_data, 0);
    $display("seq mid_reset pulses=%0d", p_step.size());

    // Randomized run against the reference model
    do_reset();
    use_model = 1;
    for (int i = 0; i < 3000; i++) begin
      snd = ($urandom_range(1, 0) == 1);
      eth_tx_ready = ($urandom_range(9, 0) < 4);
      ppu_send = ($urandom_range(9, 0) < 3);
      ppu_ready = ($urandom_range(1, 0) == 1);
      uad = ($urandom_range(9, 0) < 3);
      sac = ($urandom_range(9, 0) < 2);
      interface_data = $urandom;
      accel_done = ($urandom_range(9, 0) < 2);
      accel_result = ($urandom_range(1, 0) == 1);
      key_valid = ($urandom_range(19, 0) < 2);
      key_code = 8'($urandom);
      eth_rx_valid = ($urandom_range(9, 0) < 3);
      eth_rx_data = $urandom;
      step();
    end
    use_model = 0;
    $display("seq random steps=3000 pulses=%0d", p_step.size());

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
